// File: rtl/prio_enc_pkg.sv
// Shared definitions for the scanning priority encoder: FSM states, mode
// encodings, the WIDTH legality rule and the 4:2 leaf encoder.
package prio_enc_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    localparam logic MODE_SINGLE = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Legal widths are the powers of four from 16 to 256.
    function automatic bit width_is_legal(input int w);
        return (w == 16) || (w == 64) || (w == 256);
    endfunction

    // Highest-index-wins 4:2 encoder; an all-zero input encodes to 0.
    function automatic logic [1:0] enc4(input logic [3:0] v);
        logic [1:0] r;
        if (v[3]) begin
            r = 2'd3;
        end else if (v[2]) begin
            r = 2'd2;
        end else if (v[1]) begin
            r = 2'd1;
        end else begin
            r = 2'd0;
        end
        return r;
    endfunction

endpackage

// File: rtl/prio_enc_tree.sv
// Combinational highest-index-wins encoder built as a recursive tree of 4:2
// encoders; each level picks the highest non-empty quarter.
module prio_enc_tree
    import prio_enc_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int IW    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IW-1:0]    idx,
    output logic             any
);

    if (WIDTH == 4) begin : g_leaf
        assign idx = enc4(vec);
        assign any = |vec;
    end else begin : g_node
        localparam int QW  = WIDTH / 4;
        localparam int SIW = IW - 2;

        logic [SIW-1:0] sub_idx [4];
        logic [3:0]     sub_any;
        logic [1:0]     sel;

        for (genvar g = 0; g < 4; g++) begin : g_sub
            prio_enc_tree #(.WIDTH(QW)) u_sub (
                .vec (vec[g*QW +: QW]),
                .idx (sub_idx[g]),
                .any (sub_any[g])
            );
        end

        assign sel = enc4(sub_any);
        assign any = |sub_any;
        assign idx = {sel, sub_idx[sel]};
    end

endmodule

// File: rtl/prio_enc_scan.sv
// Priority encoder that reports either the winning requester or every active
// requester in descending index order, one result per handshake.
module prio_enc_scan
    import prio_enc_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int IW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IW-1:0]    out_idx,
    output logic             out_none,
    output logic             out_last,
    output logic [IW:0]      out_seq
);

    if (!width_is_legal(WIDTH)) begin : g_bad_width
        $error("prio_enc_scan: WIDTH must be 16, 64 or 256");
    end

    localparam logic [WIDTH-1:0] VEC_ONE = WIDTH'(1);
    localparam logic [IW:0]      SEQ_ONE = (IW+1)'(1);

    state_t           state_r, state_n;
    logic [WIDTH-1:0] pending_r, pending_n;
    logic             mode_r, mode_n;
    logic [IW:0]      seq_r, seq_n;
    logic [IW-1:0]    win_idx_s;
    logic             any_s;
    logic             one_hot_s;
    logic             last_s;

    prio_enc_tree #(.WIDTH(WIDTH)) u_tree (
        .vec (pending_r),
        .idx (win_idx_s),
        .any (any_s)
    );

    // Clearing the lowest set bit leaves zero exactly when at most one bit was set.
    assign one_hot_s = any_s && ((pending_r & (pending_r - VEC_ONE)) == '0);
    assign last_s    = (mode_r == MODE_SINGLE) || !any_s || one_hot_s;

    // State, pending vector, mode and result ordinal registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            pending_r <= '0;
            mode_r    <= MODE_SINGLE;
            seq_r     <= '0;
        end else begin
            state_r   <= state_n;
            pending_r <= pending_n;
            mode_r    <= mode_n;
            seq_r     <= seq_n;
        end
    end

    // Next-state logic; flush overrides any handshake in the same cycle.
    always_comb begin
        state_n   = state_r;
        pending_n = pending_r;
        mode_n    = mode_r;
        seq_n     = seq_r;
        if (flush) begin
            state_n   = IDLE;
            pending_n = '0;
            mode_n    = MODE_SINGLE;
            seq_n     = '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        state_n   = EMIT;
                        pending_n = in_vec;
                        mode_n    = in_mode;
                        seq_n     = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        pending_n = pending_r & ~(VEC_ONE << win_idx_s);
                        seq_n     = seq_r + SEQ_ONE;
                        if (last_s) begin
                            state_n = IDLE;
                        end else begin
                            state_n = EMIT;
                        end
                    end else begin
                        state_n = EMIT;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // Result outputs are driven only while emitting and read as zero otherwise.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_idx   = '0;
        out_none  = 1'b0;
        out_last  = 1'b0;
        out_seq   = '0;
        if (state_r == EMIT) begin
            out_valid = 1'b1;
            out_idx   = win_idx_s;
            out_none  = !any_s;
            out_last  = last_s;
            out_seq   = seq_r;
        end else begin
            in_ready = 1'b1;
        end
    end

endmodule

// File: tb/tb_prio_enc_scan.sv
// Directed and model-checked bench for prio_enc_scan at WIDTH 16, 64 and 256;
// one DUT is selected at a time and its outputs are muxed onto common signals.
module tb_prio_enc_scan;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   sel;
    logic         flush, in_valid, in_mode, out_ready;
    logic [255:0] in_vec;

    logic         in_ready, out_valid, out_none, out_last;
    logic [7:0]   obs_idx;
    logic [8:0]   obs_seq;

    logic       ir_b, ov_b, on_b, ol_b;  logic [3:0] ix_b;  logic [4:0] sq_b;
    logic       ir_a, ov_a, on_a, ol_a;  logic [5:0] ix_a;  logic [6:0] sq_a;
    logic       ir_c, ov_c, on_c, ol_c;  logic [7:0] ix_c;  logic [8:0] sq_c;

    int n_checks = 0;
    int n_fail   = 0;
    int got_idx[$];
    int got_seq[$];
    bit got_last[$];
    bit got_none[$];
    int exp_idx[$];

    always #5 clk = ~clk;

    prio_enc_scan #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .flush(flush && (sel == 2'd0)),
        .in_valid(in_valid && (sel == 2'd0)), .in_ready(ir_b), .in_vec(in_vec[15:0]),
        .in_mode(in_mode), .out_valid(ov_b), .out_ready(out_ready && (sel == 2'd0)),
        .out_idx(ix_b), .out_none(on_b), .out_last(ol_b), .out_seq(sq_b)
    );

    prio_enc_scan #(.WIDTH(64)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush && (sel == 2'd1)),
        .in_valid(in_valid && (sel == 2'd1)), .in_ready(ir_a), .in_vec(in_vec[63:0]),
        .in_mode(in_mode), .out_valid(ov_a), .out_ready(out_ready && (sel == 2'd1)),
        .out_idx(ix_a), .out_none(on_a), .out_last(ol_a), .out_seq(sq_a)
    );

    prio_enc_scan #(.WIDTH(256)) u_dut256 (
        .clk(clk), .rst_n(rst_n), .flush(flush && (sel == 2'd2)),
        .in_valid(in_valid && (sel == 2'd2)), .in_ready(ir_c), .in_vec(in_vec),
        .in_mode(in_mode), .out_valid(ov_c), .out_ready(out_ready && (sel == 2'd2)),
        .out_idx(ix_c), .out_none(on_c), .out_last(ol_c), .out_seq(sq_c)
    );

    always_comb begin
        case (sel)
            2'd0: begin
                in_ready = ir_b; out_valid = ov_b; out_none = on_b; out_last = ol_b;
                obs_idx = 8'(ix_b); obs_seq = 9'(sq_b);
            end
            2'd1: begin
                in_ready = ir_a; out_valid = ov_a; out_none = on_a; out_last = ol_a;
                obs_idx = 8'(ix_a); obs_seq = 9'(sq_a);
            end
            default: begin
                in_ready = ir_c; out_valid = ov_c; out_none = on_c; out_last = ol_c;
                obs_idx = ix_c; obs_seq = sq_c;
            end
        endcase
    end

    // Called at a negedge while idle; returns at the first negedge in EMIT.
    task automatic send(input logic [255:0] v, input logic m);
        in_vec   = v;
        in_mode  = m;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Collects transferred results until the last one (bounded).
    task automatic drain(input bit bp, output bit timed_out);
        got_idx.delete(); got_seq.delete(); got_last.delete(); got_none.delete();
        timed_out = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && out_ready) begin
                got_idx.push_back(int'(obs_idx));
                got_seq.push_back(int'(obs_seq));
                got_last.push_back(out_last);
                got_none.push_back(out_none);
                if (out_last) timed_out = 1'b0;
            end
            @(negedge clk);
            if (!timed_out) break;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || obs_idx !== 8'd0 || obs_seq !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b ready=%b idx=%0d seq=%0d, required 0 1 0 0",
                     out_valid, in_ready, obs_idx, obs_seq);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: valid=%b ready=%b, required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_single();
        logic [255:0] v;
        sel = 2'd1;
        v = '0; v[5] = 1'b1; v[40] = 1'b1; v[63] = 1'b1;
        send(v, 1'b0);
        n_checks++;
        if (out_valid !== 1'b1 || obs_idx !== 8'd63 || out_last !== 1'b1 ||
            obs_seq !== 9'd0 || out_none !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL single_result: valid=%b idx=%0d last=%b seq=%0d none=%b ready=%b, required 1 63 1 0 0 0",
                     out_valid, obs_idx, out_last, obs_seq, out_none, in_ready);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_return: ready=%b valid=%b, required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_scan();
        logic [255:0] v;
        bit to;
        int e_idx[3] = '{50, 17, 2};
        sel = 2'd1;
        v = '0; v[2] = 1'b1; v[17] = 1'b1; v[50] = 1'b1;
        send(v, 1'b1);
        drain(1'b0, to);
        n_checks++;
        if (to || got_idx.size() != 3) begin
            n_fail++;
            $display("FAIL scan_count: got %0d results (timeout=%b), required 3", got_idx.size(), to);
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (got_idx[k] != e_idx[k] || got_seq[k] != k || got_last[k] != (k == 2)) begin
                    n_fail++;
                    $display("FAIL scan_item[%0d]: idx=%0d seq=%0d last=%b, required %0d %0d %b",
                             k, got_idx[k], got_seq[k], got_last[k], e_idx[k], k, k == 2);
                end
            end
        end
    endtask

    task automatic test_zero();
        bit to;
        sel = 2'd1;
        for (int m = 0; m < 2; m++) begin
            send('0, 1'(m));
            drain(1'b0, to);
            n_checks++;
            if (to || got_idx.size() != 1 || got_idx[0] != 0 || got_none[0] != 1'b1 ||
                got_last[0] != 1'b1 || got_seq[0] != 0) begin
                n_fail++;
                $display("FAIL zero_mode%0d: count=%0d timeout=%b, required one result none=1 idx=0 last=1",
                         m, got_idx.size(), to);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [255:0] v;
        bit to;
        sel = 2'd1;
        v = '0; v[3] = 1'b1; v[9] = 1'b1;
        send(v, 1'b1);
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (out_valid !== 1'b1 || obs_idx !== 8'd9 || obs_seq !== 9'd0 || out_last !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: valid=%b idx=%0d seq=%0d last=%b, required 1 9 0 0",
                         k, out_valid, obs_idx, obs_seq, out_last);
            end
            @(negedge clk);
        end
        drain(1'b0, to);
        n_checks++;
        if (to || got_idx.size() != 2 || got_idx[0] != 9 || got_idx[1] != 3 ||
            got_seq[0] != 0 || got_seq[1] != 1 || got_last[1] != 1'b1) begin
            n_fail++;
            $display("FAIL hold_drain: count=%0d timeout=%b, required idx 9,3 seq 0,1", got_idx.size(), to);
        end
    endtask

    task automatic test_flush();
        bit to;
        sel = 2'd0;
        send(256'hFFFF, 1'b1);
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (out_valid !== 1'b1 || obs_idx !== 8'(15 - k) || obs_seq !== 9'(k)) begin
                n_fail++;
                $display("FAIL flush_pre[%0d]: valid=%b idx=%0d seq=%0d, required 1 %0d %0d",
                         k, out_valid, obs_idx, obs_seq, 15 - k, k);
            end
            @(negedge clk);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || obs_idx !== 8'd0 ||
            obs_seq !== 9'd0 || out_last !== 1'b0 || out_none !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle: valid=%b ready=%b idx=%0d seq=%0d last=%b none=%b, required 0 1 0 0 0 0",
                     out_valid, in_ready, obs_idx, obs_seq, out_last, out_none);
        end
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_quiet%0d: valid=%b, required 0", k, out_valid);
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
        send(256'h0001, 1'b1);
        drain(1'b0, to);
        n_checks++;
        if (to || got_idx.size() != 1 || got_idx[0] != 0 || got_seq[0] != 0 || got_none[0] != 1'b0) begin
            n_fail++;
            $display("FAIL flush_reuse: count=%0d timeout=%b, required one result idx=0 seq=0", got_idx.size(), to);
        end
    endtask

    task automatic test_reset_mid();
        sel = 2'd0;
        send(256'hFFFF, 1'b1);
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || obs_idx !== 8'd0 ||
            obs_seq !== 9'd0 || out_last !== 1'b0 || out_none !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: valid=%b ready=%b idx=%0d seq=%0d last=%b none=%b, required 0 1 0 0 0 0",
                     out_valid, in_ready, obs_idx, obs_seq, out_last, out_none);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_quiet%0d: valid=%b, required 0", k, out_valid);
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_random(input logic [1:0] s, input int w, input int iters);
        logic [255:0] v;
        logic         m;
        bit           to;
        int           n_exp;
        sel = s;
        for (int it = 0; it < iters; it++) begin
            for (int j = 0; j < 8; j++) v[j*32 +: 32] = $urandom();
            if ($urandom_range(0, 1) == 1) for (int j = 0; j < 8; j++) v[j*32 +: 32] &= $urandom();
            if ($urandom_range(0, 7) == 0) v = '0;
            for (int i = w; i < 256; i++) v[i] = 1'b0;
            m = 1'($urandom_range(0, 1));
            exp_idx.delete();
            for (int i = w - 1; i >= 0; i--) begin
                if (v[i] && !(m == 1'b0 && exp_idx.size() > 0)) exp_idx.push_back(i);
            end
            n_exp = (exp_idx.size() == 0) ? 1 : exp_idx.size();
            send(v, m);
            drain(1'b1, to);
            n_checks++;
            if (to || got_idx.size() != n_exp) begin
                n_fail++;
                $display("FAIL rand_w%0d_count[%0d]: got %0d (timeout=%b), required %0d",
                         w, it, got_idx.size(), to, n_exp);
            end else begin
                for (int k = 0; k < n_exp; k++) begin
                    n_checks++;
                    if (got_seq[k] != k || got_last[k] != (k == n_exp - 1) ||
                        got_none[k] != (exp_idx.size() == 0) ||
                        got_idx[k] != ((exp_idx.size() == 0) ? 0 : exp_idx[k])) begin
                        n_fail++;
                        $display("FAIL rand_w%0d[%0d][%0d]: idx=%0d seq=%0d last=%b none=%b, required %0d %0d %b %b",
                                 w, it, k, got_idx[k], got_seq[k], got_last[k], got_none[k],
                                 (exp_idx.size() == 0) ? 0 : exp_idx[k], k, k == n_exp - 1,
                                 exp_idx.size() == 0);
                    end
                end
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        sel       = 2'd1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_mode   = 1'b0;
        out_ready = 1'b0;
        in_vec    = '0;
        #12;
        test_reset();
        test_single();
        test_scan();
        test_zero();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random(2'd0, 16, 12);
        test_random(2'd1, 64, 12);
        test_random(2'd2, 256, 6);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
